// File: rtl/local_hist_table_pkg.sv
// Shared fetch-unit definitions for the local history table and its PHT neighbour:
// table geometry defaults, PHT counter encodings and the retire update-queue entry.
package local_hist_table_pkg;

    localparam int LHT_ENTRIES    = 1024;
    localparam int LOG_LHT        = 10;
    localparam int HIST_WIDTH     = 10;
    localparam int DEF_PC_WIDTH   = 64;
    localparam int DEF_UPDQ_DEPTH = 4;
    localparam int DEF_LOG_UPDQ   = 2;

    typedef enum logic [1:0] {
        PHT_SNT = 2'b00,
        PHT_WNT = 2'b01,
        PHT_WT  = 2'b10,
        PHT_ST  = 2'b11
    } pht_ctr_e;

    typedef struct packed {
        logic [LOG_LHT-1:0] idx;
        logic               dir;
    } updq_entry_t;

endpackage

// File: rtl/local_hist_table_updq.sv
// Retire update queue: two pushes (program order) and one pop per cycle.
// Handshake: an entry is taken only on a cycle where ready_o is high; pops are gated by count.
module lht_updq
    import local_hist_table_pkg::*;
#(
    parameter int DEPTH = DEF_UPDQ_DEPTH,
    parameter int LOG   = DEF_LOG_UPDQ
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push0_valid_i,
    input  updq_entry_t   push0_entry_i,
    input  logic          push1_valid_i,
    input  updq_entry_t   push1_entry_i,
    input  logic          pop_i,
    output logic [LOG:0]  count_o,
    output updq_entry_t   head_o,
    output logic          ready_o
);

    updq_entry_t      r_mem [DEPTH];
    logic [LOG-1:0]   r_wr_ptr;
    logic [LOG-1:0]   r_rd_ptr;
    logic [LOG:0]     r_count;

    logic             w_push0;
    logic             w_push1;
    logic             w_pop;
    logic [1:0]       w_n_push;
    logic [LOG-1:0]   w_wr1_ptr;

    // Room for two more entries is required so a dual retire never half-fits.
    assign ready_o   = (r_count <= (LOG+1)'(DEPTH-2));
    assign w_push0   = ready_o & push0_valid_i;
    assign w_push1   = ready_o & push1_valid_i;
    assign w_pop     = pop_i & (r_count != '0);
    assign w_n_push  = {1'b0, w_push0} + {1'b0, w_push1};
    assign w_wr1_ptr = r_wr_ptr + LOG'(w_push0);
    assign count_o   = r_count;
    assign head_o    = r_mem[r_rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + LOG'(w_n_push);
            r_rd_ptr <= r_rd_ptr + LOG'(w_pop);
            r_count  <= r_count + (LOG+1)'(w_n_push) - (LOG+1)'(w_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (w_push0) r_mem[r_wr_ptr]  <= push0_entry_i;
        if (w_push1) r_mem[w_wr1_ptr] <= push1_entry_i;
    end

endmodule

// File: rtl/local_hist_table.sv
// Local branch history table feeding the local PHT: fetch lookup plus queued retire updates.
// Build option LHT_BYPASS_EN: same-cycle lookup of the entry being updated sees the new history.
module local_hist_table
    import local_hist_table_pkg::*;
#(
    parameter int PC_WIDTH   = DEF_PC_WIDTH,
    parameter int UPDQ_DEPTH = DEF_UPDQ_DEPTH,
    parameter int LOG_UPDQ   = DEF_LOG_UPDQ
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  fetch_valid_i,
    input  logic [PC_WIDTH-1:0]   fetch_pc_i,
    output logic [HIST_WIDTH-1:0] pht_rd_index_o,
    output logic                  pht_rd_valid_o,
    input  logic                  retire0_valid_i,
    input  logic [PC_WIDTH-1:0]   retire0_pc_i,
    input  logic                  retire0_brdir_i,
    input  logic                  retire1_valid_i,
    input  logic [PC_WIDTH-1:0]   retire1_pc_i,
    input  logic                  retire1_brdir_i,
    output logic                  retire_ready_o,
    output logic [HIST_WIDTH-1:0] pht_wt_index_o,
    output logic                  pht_brdir_we_o,
    output logic                  pht_brdir_o
);

    logic [HIST_WIDTH-1:0] r_lht [LHT_ENTRIES];

    logic [LOG_LHT-1:0]    w_fetch_idx;
    updq_entry_t           w_push0;
    updq_entry_t           w_push1;
    updq_entry_t           w_head;
    logic [LOG_UPDQ:0]     w_count;
    logic                  w_pop;
    logic [HIST_WIDTH-1:0] w_head_hist;
    logic [HIST_WIDTH-1:0] w_new_hist;
    logic [HIST_WIDTH-1:0] w_rd_hist;
    logic                  w_unused_pc_bits;

    assign w_fetch_idx = fetch_pc_i[LOG_LHT+1:2];
    assign w_push0     = {retire0_pc_i[LOG_LHT+1:2], retire0_brdir_i};
    assign w_push1     = {retire1_pc_i[LOG_LHT+1:2], retire1_brdir_i};
    assign w_unused_pc_bits = ^{fetch_pc_i[PC_WIDTH-1:LOG_LHT+2], fetch_pc_i[1:0],
                                retire0_pc_i[PC_WIDTH-1:LOG_LHT+2], retire0_pc_i[1:0],
                                retire1_pc_i[PC_WIDTH-1:LOG_LHT+2], retire1_pc_i[1:0]};

    lht_updq #(
        .DEPTH (UPDQ_DEPTH),
        .LOG   (LOG_UPDQ)
    ) u_updq (
        .clock         (clock),
        .reset         (reset),
        .push0_valid_i (retire0_valid_i),
        .push0_entry_i (w_push0),
        .push1_valid_i (retire1_valid_i),
        .push1_entry_i (w_push1),
        .pop_i         (w_pop),
        .count_o       (w_count),
        .head_o        (w_head),
        .ready_o       (retire_ready_o)
    );

    // Drain is registered from the queue head only; no fall-through from the retire ports.
    assign w_pop       = (w_count != '0);
    assign w_head_hist = r_lht[w_head.idx];
    assign w_new_hist  = {w_head_hist[HIST_WIDTH-2:0], w_head.dir};

`ifdef LHT_BYPASS_EN
    assign w_rd_hist = (w_pop && (w_head.idx == w_fetch_idx)) ? w_new_hist : r_lht[w_fetch_idx];
`else
    assign w_rd_hist = r_lht[w_fetch_idx];
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LHT_ENTRIES; i++) r_lht[i] <= '0;
        end else if (w_pop) begin
            r_lht[w_head.idx] <= w_new_hist;
        end
    end

    // The PHT is trained with the pre-update history, i.e. the index it was read with.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pht_rd_index_o <= '0;
            pht_rd_valid_o <= 1'b0;
            pht_wt_index_o <= '0;
            pht_brdir_we_o <= 1'b0;
            pht_brdir_o    <= 1'b0;
        end else begin
            pht_rd_valid_o <= fetch_valid_i;
            if (fetch_valid_i) pht_rd_index_o <= w_rd_hist;
            pht_brdir_we_o <= w_pop;
            if (w_pop) begin
                pht_wt_index_o <= w_head_hist;
                pht_brdir_o    <= w_head.dir;
            end
        end
    end

endmodule
